// File: rtl/mult_div_unit.sv
// Execute-stage multiply/divide unit owning HI/LO, with busy-counter latency.
// Define MDU_MADD_EN to enable madd/maddu/msub/msubu (ops 7-10).
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  MDop,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        rd_sel,
    output logic        busy,
    output logic [31:0] md_rdata,
    output logic [31:0] HI,
    output logic [31:0] LO
);

`ifdef MDU_MADD_EN
    localparam logic maddEn = 1'b1;
`else
    localparam logic maddEn = 1'b0;
`endif

    localparam logic [1:0] MODE_NONE = 2'd0;
    localparam logic [1:0] MODE_LOAD = 2'd1;
    localparam logic [1:0] MODE_ADD  = 2'd2;
    localparam logic [1:0] MODE_SUB  = 2'd3;

    logic opMult, opMultu, opDiv, opDivu, opMadd, opMsub;
    logic maddSigned, isLaunch, isMultClass;
    logic [3:0]  count, launchCount;
    logic [63:0] pending, nextPend, sProd, uProd, hiLo;
    logic [1:0]  pendMode, nextMode;
    logic [31:0] magA, magB, sDivisor, uDivisor;
    logic [31:0] sQuotMag, sRemMag, sQuot, sRem, uQuot, uRem;

    assign opMult  = (MDop == 4'd1);
    assign opMultu = (MDop == 4'd2);
    assign opDiv   = (MDop == 4'd3);
    assign opDivu  = (MDop == 4'd4);
    assign opMadd  = maddEn && (MDop == 4'd7 || MDop == 4'd8);
    assign opMsub  = maddEn && (MDop == 4'd9 || MDop == 4'd10);
    assign maddSigned = (MDop == 4'd7) || (MDop == 4'd9);

    assign isMultClass = opMult | opMultu | opMadd | opMsub;
    assign isLaunch    = isMultClass | opDiv | opDivu;
    assign launchCount = isMultClass ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);

    // Sign-extend to 64 bits so the low 64 product bits are the signed result.
    assign sProd = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    assign uProd = {32'd0, A} * {32'd0, B};

    assign magA = A[31] ? (~A + 32'd1) : A;
    assign magB = B[31] ? (~B + 32'd1) : B;

    // Divisor forced nonzero; a zero divide never writes HI/LO anyway.
    assign sDivisor = (magB == 32'd0) ? 32'd1 : magB;
    assign uDivisor = (B == 32'd0) ? 32'd1 : B;

    assign sQuotMag = magA / sDivisor;
    assign sRemMag  = magA % sDivisor;
    assign sQuot    = (A[31] ^ B[31]) ? (~sQuotMag + 32'd1) : sQuotMag;
    assign sRem     = A[31] ? (~sRemMag + 32'd1) : sRemMag;
    assign uQuot    = A / uDivisor;
    assign uRem     = A % uDivisor;

    always_comb begin
        nextPend = 64'd0;
        nextMode = MODE_NONE;
        unique case (1'b1)
            opMult: begin
                nextPend = sProd;
                nextMode = MODE_LOAD;
            end
            opMultu: begin
                nextPend = uProd;
                nextMode = MODE_LOAD;
            end
            opDiv: begin
                nextPend = {sRem, sQuot};
                nextMode = (B == 32'd0) ? MODE_NONE : MODE_LOAD;
            end
            opDivu: begin
                nextPend = {uRem, uQuot};
                nextMode = (B == 32'd0) ? MODE_NONE : MODE_LOAD;
            end
            opMadd: begin
                nextPend = maddSigned ? sProd : uProd;
                nextMode = MODE_ADD;
            end
            opMsub: begin
                nextPend = maddSigned ? sProd : uProd;
                nextMode = MODE_SUB;
            end
            default: ;
        endcase
    end

    assign hiLo = {HI, LO};

    always_ff @(posedge clk) begin
        if (reset) begin
            busy     <= 1'b0;
            count    <= 4'd0;
            pending  <= 64'd0;
            pendMode <= MODE_NONE;
            HI       <= 32'd0;
            LO       <= 32'd0;
        end else if (busy) begin
            if (count == 4'd1) begin
                busy  <= 1'b0;
                count <= 4'd0;
                case (pendMode)
                    MODE_LOAD: {HI, LO} <= pending;
                    MODE_ADD:  {HI, LO} <= hiLo + pending;
                    MODE_SUB:  {HI, LO} <= hiLo - pending;
                    default: ;
                endcase
            end else begin
                count <= count - 4'd1;
            end
        end else if (start && isLaunch) begin
            busy     <= 1'b1;
            count    <= launchCount;
            pending  <= nextPend;
            pendMode <= nextMode;
        end else if (MDop == 4'd5) begin
            HI <= A;
        end else if (MDop == 4'd6) begin
            LO <= A;
        end
    end

    assign md_rdata = rd_sel ? HI : LO;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed cases plus random ops
// checked every cycle against an arithmetic reference model.
module tb_mult_div_unit;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

`ifdef MDU_MADD_EN
    localparam bit maddOn = 1'b1;
`else
    localparam bit maddOn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, start, rd_sel;
    logic [3:0]  MDop;
    logic [31:0] A, B;
    logic        busy;
    logic [31:0] md_rdata, HI, LO;

    int nTests = 0;
    int nFail  = 0;

    logic [63:0] mHiLo = 64'd0;
    logic [63:0] mPend = 64'd0;
    int          mLeft = 0;
    int          mMode = 0;

    mult_div_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk(clk), .reset(reset), .start(start), .MDop(MDop),
        .A(A), .B(B), .rd_sel(rd_sel), .busy(busy),
        .md_rdata(md_rdata), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nTests++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit launchOp(input logic [3:0] op);
        return (op >= 4'd1 && op <= 4'd4) || (maddOn && op >= 4'd7 && op <= 4'd10);
    endfunction

    // Reference: one architectural step per clock edge using plain arithmetic.
    task automatic modelEdge();
        longint sa, sb, q, r;
        logic [63:0] ua, ub, prod;
        sa = longint'($signed(A));
        sb = longint'($signed(B));
        ua = {32'd0, A};
        ub = {32'd0, B};
        if (reset) begin
            mHiLo = 64'd0; mPend = 64'd0; mLeft = 0; mMode = 0;
            return;
        end
        if (mLeft > 0) begin
            if (mLeft == 1) begin
                if (mMode == 1) mHiLo = mPend;
                else if (mMode == 2) mHiLo = mHiLo + mPend;
                else if (mMode == 3) mHiLo = mHiLo - mPend;
            end
            mLeft--;
        end else if (start && launchOp(MDop)) begin
            mMode = 1;
            prod  = (MDop == 4'd7 || MDop == 4'd9 || MDop == 4'd1) ? 64'(sa * sb) : ua * ub;
            case (MDop)
                4'd1, 4'd2: mPend = prod;
                4'd3: begin
                    if (B == 32'd0) mMode = 0;
                    else begin
                        q = sa / sb; r = sa % sb;
                        mPend = {r[31:0], q[31:0]};
                    end
                end
                4'd4: begin
                    if (B == 32'd0) mMode = 0;
                    else mPend = {32'(ua % ub), 32'(ua / ub)};
                end
                4'd7, 4'd8: begin mPend = prod; mMode = 2; end
                default: begin mPend = prod; mMode = 3; end
            endcase
            mLeft = (MDop == 4'd3 || MDop == 4'd4) ? DIV_N : MULT_N;
        end else if (MDop == 4'd5) begin
            mHiLo[63:32] = A;
        end else if (MDop == 4'd6) begin
            mHiLo[31:0] = A;
        end
    endtask

    task automatic step(input logic r, input logic s, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b, input logic rs);
        reset = r; start = s; MDop = op; A = a; B = b; rd_sel = rs;
        @(posedge clk);
        modelEdge();
        #1;
        check("busy", 32'(busy), 32'(mLeft > 0));
        check("HI", HI, mHiLo[63:32]);
        check("LO", LO, mHiLo[31:0]);
        check("md_rdata", md_rdata, rd_sel ? mHiLo[63:32] : mHiLo[31:0]);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 4'd0, $urandom, $urandom, 1'($urandom));
    endtask

    task automatic runOp(input string tag, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b, input int expCycles);
        int n = 0;
        step(1'b0, 1'b1, op, a, b, 1'b0);
        while (busy && n < 20) begin
            n++;
            idle();
        end
        check(tag, 32'(n), 32'(expCycles));
    endtask

    function automatic logic [31:0] randOperand();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'h1;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        step(1'b1, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
        step(1'b1, 1'b0, 4'd0, 32'd0, 32'd0, 1'b1);
        check("rst_HI", HI, 32'h0);
        check("rst_LO", LO, 32'h0);
        check("rst_busy", 32'(busy), 32'h0);

        runOp("mult_cycles", 4'd1, 32'hFFFF_FFFD, 32'd5, 5);
        check("mult_HI", HI, 32'hFFFF_FFFF);
        check("mult_LO", LO, 32'hFFFF_FFF1);

        runOp("multu_cycles", 4'd2, 32'hFFFF_FFFF, 32'd2, 5);
        check("multu_HI", HI, 32'h0000_0001);
        check("multu_LO", LO, 32'hFFFF_FFFE);

        runOp("div_cycles", 4'd3, 32'hFFFF_FFF9, 32'd2, 10);
        check("div_LO", LO, 32'hFFFF_FFFD);
        check("div_HI", HI, 32'hFFFF_FFFF);

        step(1'b0, 1'b0, 4'd5, 32'h1234, 32'd0, 1'b1);
        check("mthi_HI", HI, 32'h1234);
        check("mthi_busy", 32'(busy), 32'h0);
        runOp("div0_cycles", 4'd4, 32'd9, 32'd0, 10);
        check("div0_HI", HI, 32'h1234);
        check("div0_LO", LO, 32'hFFFF_FFFD);

        runOp("ovf_cycles", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10);
        check("ovf_LO", LO, 32'h8000_0000);
        check("ovf_HI", HI, 32'h0);

        step(1'b0, 1'b1, 4'd1, 32'd2, 32'd3, 1'b0);
        step(1'b0, 1'b1, 4'd3, 32'd7, 32'd1, 1'b0);
        step(1'b0, 1'b0, 4'd5, 32'hDEAD, 32'd1, 1'b1);
        step(1'b0, 1'b1, 4'd4, 32'd7, 32'd2, 1'b0);
        step(1'b0, 1'b0, 4'd6, 32'hBEEF, 32'd1, 1'b0);
        idle();
        check("ign_busy", 32'(busy), 32'h0);
        check("ign_HI", HI, 32'h0);
        check("ign_LO", LO, 32'd6);

        step(1'b0, 1'b1, 4'd3, 32'd100, 32'd7, 1'b0);
        repeat (3) idle();
        step(1'b1, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
        check("rstmid_busy", 32'(busy), 32'h0);
        check("rstmid_HI", HI, 32'h0);
        check("rstmid_LO", LO, 32'h0);
        repeat (12) idle();
        check("rstmid_late_HI", HI, 32'h0);
        check("rstmid_late_LO", LO, 32'h0);

        step(1'b0, 1'b0, 4'd6, 32'hFFFF_FFFF, 32'd0, 1'b0);
        runOp("madd_cycles", 4'd7, 32'd1, 32'd1, maddOn ? MULT_N : 0);
        check("madd_HI", HI, maddOn ? 32'h1 : 32'h0);
        check("madd_LO", LO, maddOn ? 32'h0 : 32'hFFFF_FFFF);

        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 299) == 0), 1'($urandom), 4'($urandom_range(0, 15)),
                 randOperand(), randOperand(), 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Execute-stage multiply/divide unit for the five-stage pipeline; owns the HI/LO registers.
- Accepts one operation per launch from the E-stage controller. Models multi-cycle latency with a busy counter.
- Drives `start`/`busy` to the hazard unit, which stalls D-stage mult/div-class instructions while `start|busy` is high.
- Provides an mfhi/mflo read port to the E-stage result mux.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (and madd-class when enabled); legal range 1..15.
- DIV_CYCLES, 10, busy cycles for div/divu; legal range 1..15.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous active-high reset
- start  input  1  launch pulse from E-stage controller; meaningful only with a launch op
- MDop  input  4  op: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 madd, 8 maddu, 9 msub, 10 msubu, others none
- A  input  32  rs operand (forwarded E value)
- B  input  32  rt operand (forwarded E value)
- rd_sel  input  1  1 = read HI, 0 = read LO
- busy  output  1  operation in flight
- md_rdata  output  32  combinational read of HI or LO
- HI  output  32  architectural HI
- LO  output  32  architectural LO

Behaviour:
- Reset (synchronous, next edge):
  - HI=0, LO=0, busy=0, counter=0, pending result=0.
  - Reset mid-operation discards the pending result; HI/LO remain 0.
- Launch ops are 1-4 (7-10 only with the feature). A launch happens on an edge where start=1, op is a launch op and busy=0:
  - Result is computed from A/B in that cycle and held in a pending 64-bit register.
  - Counter loads MULT_CYCLES or DIV_CYCLES; busy goes to 1 at the same edge.
- Busy counting:
  - While busy, the counter decrements every edge.
  - At the edge where the counter equals 1: HI/LO load the pending value, busy goes to 0, counter goes to 0.
  - Timing: start in cycle T gives busy high for T+1..T+N, with the new HI/LO visible from T+N+1.
- Ignored launches:
  - start=1 while busy=1 is ignored; the in-flight op is unaffected.
  - start=1 with a non-launch op is ignored.
- Arithmetic:
  - mult: signed 32x32 to 64; {HI,LO}=product.
  - multu: unsigned 32x32 to 64; {HI,LO}=product.
  - div/divu: LO=quotient (signed truncates toward zero), HI=remainder (sign of dividend for signed).
  - Divide by zero (B==0): busy timing unchanged; HI and LO keep their previous values at completion.
  - Signed overflow 0x80000000/-1: LO=0x80000000, HI=0.
- mthi/mtlo:
  - Write HI or LO with A at the next edge, independent of start, only when busy=0.
  - Ignored when busy=1.
  - Do not assert busy.
- Priority at a single edge: reset > completion write > mthi/mtlo. mthi/mtlo are already gated off while busy, so they cannot collide with a completion write.
- Read port: md_rdata = rd_sel ? HI : LO, purely combinational. During busy it returns the old (pre-op) value; the hazard unit prevents mfhi/mflo from reaching E then.
- No sticky or internal states beyond IDLE (busy=0) and RUN (busy=1).

Optional Feature:
- Macro MDU_MADD_EN.
- Defined:
  - Ops 7-10 are launch ops with MULT_CYCLES latency.
  - Completion computes {HI,LO} = {HI,LO} ± product, using the HI/LO value at completion time, modulo 2^64.
  - madd/msub use a signed product; maddu/msubu use an unsigned product.
- Undefined: ops 7-10 behave as op 0 (no launch, no write, busy stays 0).

Test Plan:
- reset; start=1, MDop=1, A=0xFFFFFFFD, B=5 -> busy=1 for exactly 5 cycles; HI=0xFFFFFFFF, LO=0xFFFFFFF1 on the cycle busy falls.
- MDop=2, A=0xFFFFFFFF, B=2 -> HI=0x00000001, LO=0xFFFFFFFE after 5 busy cycles.
- MDop=3, A=0xFFFFFFF9 (-7), B=2 -> busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- MDop=5, A=0x1234 -> HI=0x1234 next cycle with busy=0; then MDop=4, A=9, B=0 -> busy 10 cycles, HI=0x1234 and LO unchanged.
- Launch div, then assert reset at busy cycle 4 -> next edge busy=0, HI=LO=0, and no later write occurs.
- Under MDU_MADD_EN: HI=0, LO=0xFFFFFFFF, MDop=7, A=1, B=1 -> HI=1, LO=0. Without the macro, the same stimulus leaves busy=0 and HI/LO unchanged.
